button_event_decoder: RTL and testbench

Consumer side of the push-button input path. Takes the clean, clock-synchronous level from the button debouncer and turns it into single-cycle event pulses for downstream control logic: press, release, short click, long press and auto-repeat while held. Also keeps a wrapping count of press events for display or debug.

---
 rtl/button_event_decoder.sv | 123 ++++++++++++
 tb/tb_button_event_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into single-cycle press, release,
// click, long-press and auto-repeat pulses, plus a wrapping 8-bit press counter.
module button_event_decoder #(
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_debounced,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       click_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   localparam int unsigned CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHORT,
      S_LONG
   } state_t;

   state_t           r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_prev;
   logic             r_press, r_release, r_click, r_long, r_repeat, r_held;
   logic             w_press, w_release, w_click, w_long, w_repeat, w_held;
   logic [7:0]       r_count, w_count;
   logic             w_rise;

   assign w_rise = button_debounced & ~r_prev;

   // A release always takes priority over a threshold hit on the same cycle.
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_count   = r_count;
      w_press   = 1'b0;
      w_release = 1'b0;
      w_click   = 1'b0;
      w_long    = 1'b0;
      w_repeat  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_press = 1'b1;
               w_count = r_count + 8'd1;
               w_cnt   = '0;
               w_state = S_SHORT;
            end
         end
         S_SHORT: begin
            if (!button_debounced) begin
               w_release = 1'b1;
               w_click   = 1'b1;
               w_state   = S_IDLE;
            end else if (r_cnt == LONG_LAST) begin
               w_long  = 1'b1;
               w_cnt   = '0;
               w_state = S_LONG;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_LONG: begin
            if (!button_debounced) begin
               w_release = 1'b1;
               w_state   = S_IDLE;
            end else if (r_cnt == REPEAT_LAST) begin
               w_repeat = 1'b1;
               w_cnt    = '0;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
      w_held = (w_state != S_IDLE);
   end

   // prev resets to 1 so a button already down at reset release is not a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev    <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_count   <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_click   <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_prev    <= button_debounced;
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_count   <= w_count;
         r_press   <= w_press;
         r_release <= w_release;
         r_click   <= w_click;
         r_long    <= w_long;
         r_repeat  <= w_repeat;
         r_held    <= w_held;
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign click_pulse   = r_click;
   assign long_pulse    = r_long;
   assign repeat_pulse  = r_repeat;
   assign held          = r_held;
   assign press_count   = r_count;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4;
// edge numbers count rising edges after reset deasserts.
module tb_button_event_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       button;
   logic       press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;
   logic [7:0] press_count;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int          e       = 0;
   int unsigned n_press = 0;

   always #5 clk = ~clk;

   button_event_decoder #(
      .LONG_CYCLES  (8),
      .REPEAT_CYCLES(4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .button_debounced(button),
      .press_pulse     (press_pulse),
      .release_pulse   (release_pulse),
      .click_pulse     (click_pulse),
      .long_pulse      (long_pulse),
      .repeat_pulse    (repeat_pulse),
      .held            (held),
      .press_count     (press_count)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] obs();
      return {2'b00, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
   endfunction

   // Drive the level sampled at the next edge, then observe 1 ns after it.
   task automatic step(input logic b);
      button = b;
      @(posedge clk);
      #1;
      e++;
      if (press_pulse === 1'b1) n_press++;
   endtask

   task automatic expect_out(input string name, input bit p, input bit r, input bit c,
                             input bit l, input bit rp, input bit h);
      check($sformatf("%s@%0d", name, e), {8'h00, obs()}, {10'h000, p, r, c, l, rp, h});
   endtask

   task automatic do_reset(input logic b);
      reset  = 1'b1;
      button = b;
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      e       = 0;
      n_press = 0;
      check("rst_out", {8'h00, obs()}, 16'h0000);
      check("rst_cnt", {8'h00, press_count}, 16'h0000);
   endtask

   initial begin
      reset  = 1'b1;
      button = 1'b0;

      // 1: click
      do_reset(1'b0);
      for (int k = 1; k <= 20; k++) begin
         step(k >= 10 && k <= 12);
         expect_out("click", k == 10, k == 13, k == 13, 1'b0, 1'b0, k >= 10 && k <= 12);
      end
      check("click_cnt", {8'h00, press_count}, 16'd1);

      // 2: long press with repeats; repeat at 30 loses to release
      do_reset(1'b0);
      for (int k = 1; k <= 34; k++) begin
         step(k >= 10 && k <= 29);
         expect_out("long", k == 10, k == 30, 1'b0, k == 18, k == 22 || k == 26,
                    k >= 10 && k <= 29);
      end
      check("long_cnt", {8'h00, press_count}, 16'd1);

      // 3: release on the long-threshold edge
      do_reset(1'b0);
      for (int k = 1; k <= 24; k++) begin
         step(k >= 10 && k <= 17);
         expect_out("coll", k == 10, k == 18, k == 18, 1'b0, 1'b0, k >= 10 && k <= 17);
      end

      // 4: button held through reset
      do_reset(1'b1);
      for (int k = 1; k <= 16; k++) begin
         step((k <= 5) || (k >= 9 && k <= 11));
         expect_out("hold_rst", k == 9, k == 12, k == 12, 1'b0, 1'b0, k >= 9 && k <= 11);
      end
      check("hold_rst_cnt", {8'h00, press_count}, 16'd1);

      // 5: reset during LONG
      do_reset(1'b0);
      for (int k = 1; k <= 19; k++) begin
         step(k >= 10);
         expect_out("mid_rst", k == 10, 1'b0, 1'b0, k == 18, 1'b0, k >= 10);
      end
      reset = 1'b1;
      step(1'b1);
      expect_out("mid_rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_rst_cnt", {8'h00, press_count}, 16'd0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(k < 6);
         expect_out("mid_rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // 6: 256 back-to-back clicks, counter wraps
      do_reset(1'b0);
      step(1'b0);
      expect_out("wrap_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         step(1'b1);
         expect_out("wrap_press", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 254) check("wrap_255", {8'h00, press_count}, 16'd255);
         if (i == 255) check("wrap_0", {8'h00, press_count}, 16'd0);
         step(1'b0);
         expect_out("wrap_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("wrap_npress", n_press[15:0], 16'd256);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
